// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: raster timing generator with four selectable test patterns.
// Ports: clk pixel clock; rst_n async active-low reset; en run request (sampled at frame
// boundaries); pattern_sel 0 solid/1 ramp/2 colour bars/3 checkerboard; de_out, h_sync_out,
// v_sync_out, pixel_out {R,G,B} registered stream; frame_start pulse on first active pixel;
// frame_cnt frames started since reset.
// Optional: define VPG_BORDER_EN for a 1-pixel white border over the active picture.
module vid_pattern_gen #(
   parameter int          H_ACTIVE  = 16,
   parameter int          H_FP      = 2,
   parameter int          H_SYNC    = 4,
   parameter int          H_BP      = 2,
   parameter int          V_ACTIVE  = 8,
   parameter int          V_FP      = 1,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 1,
   parameter logic        SYNC_POL  = 1'b1,
   parameter logic [23:0] SOLID_RGB = 24'h0000FF,
   parameter int          CHK_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   output logic        de_out,
   output logic        h_sync_out,
   output logic        v_sync_out,
   output logic [23:0] pixel_out,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One shared counter width wide enough for both axes, the ramp byte and the checker bit.
   localparam int CH = $clog2(H_TOTAL);
   localparam int CV = $clog2(V_TOTAL);
   localparam int W0 = CH > CV ? CH : CV;
   localparam int W1 = W0 > 8 ? W0 : 8;
   localparam int W  = W1 > CHK_SHIFT ? W1 : CHK_SHIFT + 1;
   localparam logic [W-1:0] HA     = W'(H_ACTIVE);
   localparam logic [W-1:0] H_LAST = W'(H_TOTAL - 1);
   localparam logic [W-1:0] HS0    = W'(H_ACTIVE + H_FP);
   localparam logic [W-1:0] HS1    = W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [W-1:0] VA     = W'(V_ACTIVE);
   localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);
   localparam logic [W-1:0] VS0    = W'(V_ACTIVE + V_FP);
   localparam logic [W-1:0] VS1    = W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [W-1:0] BAR_W  = W'(H_ACTIVE / 8);
`ifdef VPG_BORDER_EN
   localparam logic [W-1:0] HA_LAST = W'(H_ACTIVE - 1);
   localparam logic [W-1:0] VA_LAST = W'(V_ACTIVE - 1);
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [W-1:0] h_q, h_d, v_q, v_d;
   logic [1:0]  pat_q, pat_d;
   logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic [23:0] pix_q, pix_d;
   logic [15:0] fc_q, fc_d;
   logic        run, origin, line_end, frame_end, de, chk;
   logic [1:0]  pat;
   logic [2:0]  bar;
   logic [23:0] rgb;
`ifdef VPG_BORDER_EN
   logic        border;
`endif

   always_comb begin
      run       = state_q == RUN;
      origin    = h_q == '0 && v_q == '0;
      line_end  = h_q == H_LAST;
      frame_end = line_end && v_q == V_LAST;
      // The pattern is taken live on the first pixel so a new selection applies to a whole frame.
      pat       = origin ? pattern_sel : pat_q;
      state_d   = run ? ((frame_end && !en) ? IDLE : RUN) : (en ? RUN : IDLE);
      h_d       = (run && !line_end) ? h_q + 1'b1 : '0;
      v_d       = !run ? '0 : line_end ? (frame_end ? '0 : v_q + 1'b1) : v_q;
      pat_d     = run ? pat : pat_q;
      de        = h_q < HA && v_q < VA;
      bar       = 3'(h_q / BAR_W);
      chk       = h_q[CHK_SHIFT] ^ v_q[CHK_SHIFT];
      // Bar order white..black: R off on bars 2,3,6,7; G off on 4..7; B off on odd bars.
      rgb       = pat == 2'd0 ? SOLID_RGB
                : pat == 2'd1 ? {3{h_q[7:0]}}
                : pat == 2'd2 ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}}
                :               {24{chk}};
`ifdef VPG_BORDER_EN
      border    = h_q == '0 || h_q == HA_LAST || v_q == '0 || v_q == VA_LAST;
      pix_d     = (run && de) ? (border ? 24'hFFFFFF : rgb) : '0;
`else
      pix_d     = (run && de) ? rgb : '0;
`endif
      de_d      = run && de;
      hs_d      = (run && h_q >= HS0 && h_q < HS1) ? SYNC_POL : ~SYNC_POL;
      vs_d      = (run && v_q >= VS0 && v_q < VS1) ? SYNC_POL : ~SYNC_POL;
      fs_d      = run && origin;
      fc_d      = fs_d ? fc_q + 16'd1 : fc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         pat_q   <= '0;
         de_q    <= 1'b0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         pix_q   <= '0;
         fs_q    <= 1'b0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pat_q   <= pat_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         pix_q   <= pix_d;
         fs_q    <= fs_d;
         fc_q    <= fc_d;
      end
   end

   assign de_out      = de_q;
   assign h_sync_out  = hs_q;
   assign v_sync_out  = vs_q;
   assign pixel_out   = pix_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fc_q;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: randomized check of vid_pattern_gen against a frame-position reference model.
module tb_vid_pattern_gen;
   localparam int HA = 16;
   localparam int HT = 24;
   localparam int VA = 8;
   localparam int FT = 288;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        de_out, h_sync_out, v_sync_out, frame_start;
   logic [23:0] pixel_out;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad = 0;
   int pulses = 0;

   bit          m_run = 1'b0;
   int          m_pos = 0;
   int          m_pat = 0;
   logic [15:0] m_cnt = 16'd0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   always #5 clk = ~clk;

   vid_pattern_gen dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
      .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
      .pixel_out(pixel_out), .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   wire [63:0] obs = {20'd0, de_out, h_sync_out, v_sync_out, pixel_out, frame_start, frame_cnt};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] ref_pix(input int p, input int h, input int v);
      logic [23:0] c;
      case (p)
         0:       c = 24'h0000FF;
         1:       c = {3{8'(h)}};
         2:       c = bars[h / (HA / 8)];
         default: c = (((h >> 2) ^ (v >> 2)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      endcase
`ifdef VPG_BORDER_EN
      if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) c = 24'hFFFFFF;
`endif
      return c;
   endfunction

   // One clock: predict the outputs produced by this edge from the model's frame position,
   // advance the model with the inputs presented at the edge, then compare.
   task automatic step();
      logic [63:0] e;
      logic        de;
      int          h, v;
      if (m_run && m_pos == 0) begin
         m_pat = pattern_sel;
         m_cnt = m_cnt + 16'd1;
      end
      h  = m_pos % HT;
      v  = m_pos / HT;
      de = m_run && h < HA && v < VA;
      e  = {20'd0, de, m_run && h >= 18 && h < 22, m_run && v >= 9 && v < 11,
            de ? ref_pix(m_pat, h, v) : 24'h0, m_run && m_pos == 0, m_cnt};
      if (!m_run || m_pos == FT - 1) begin
         m_run = en;
         m_pos = 0;
      end else begin
         m_pos++;
      end
      @(posedge clk);
      #1;
      if (frame_start) pulses++;
      check("stream", obs, e);
   endtask

   // Entered 1 ns after a rising edge; leaves 6 ns after it with reset released.
   task automatic apply_reset();
      #3 rst_n = 1'b0;
      #1;
      check("rst_data", {20'd0, de_out, pixel_out, frame_start, frame_cnt}, 64'd0);
      check("rst_sync", 64'({h_sync_out, v_sync_out}), 64'd0);
      m_run = 1'b0;
      m_pos = 0;
      m_cnt = 16'd0;
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      @(posedge clk);
      #1;
      apply_reset();
      repeat (3) step();
      check("idle_de", 64'(de_out), 64'd0);
      pattern_sel = 2'd2;
      en = 1'b1;
      step();
      check("lat_one_clk", 64'(de_out), 64'd0);
      step();
      check("lat_first_px", 64'({de_out, frame_start}), 64'd3);
      check("bar0_px", 64'(pixel_out), 64'hFFFFFF);
      repeat (FT) step();
      for (int i = 0; i < 6 * FT; i++) begin
         if ($urandom_range(0, 59) == 0) pattern_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) en = ~en;
         step();
      end
      en = 1'b1;
      pattern_sel = 2'd3;
      found = 1'b0;
      for (int i = 0; i < 3 * FT && !found; i++) begin
         step();
         found = m_run && m_pos > HT && m_pos % HT == 5 && m_pos / HT < VA;
      end
      check("find_active", 64'(found), 64'd1);
      apply_reset();
      step();
      check("restart_idle", 64'(frame_start), 64'd0);
      step();
      check("restart_fs", 64'({frame_start, frame_cnt}), 64'h10001);
      found = 1'b0;
      for (int i = 0; i < FT && !found; i++) begin
         step();
         found = m_pos == 50;
      end
      pattern_sel = 2'd1;
      repeat (FT) step();
      apply_reset();
      en = 1'b1;
      pulses = 0;
      found = 1'b0;
      for (int i = 0; i < 3 * FT && !found; i++) begin
         step();
         found = m_cnt == 16'd2 && m_pos == 100;
      end
      check("reach_frame2", 64'(found), 64'd1);
      en = 1'b0;
      repeat (FT) step();
      check("stop_cnt", 64'(frame_cnt), 64'd2);
      check("stop_pulses", 64'(pulses), 64'd2);
      check("stop_idle", 64'({de_out, pixel_out}), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
